timing_capture: RTL

TIMING_CAPTURE -- requirements
Module: timing_capture

---
 rtl/timing_capture.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/timing_capture.sv
// Packs decoded video pixels in pairs into 48-bit FIFO words, tracks the line index and flags length/overflow errors.
// Latency: one write strobe the cycle after the second pixel of a pair; fifo_full drops the word and parks the line in DROP.
module timing_capture #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hvsync_polarity,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic [23:0] pixel,
    input  logic        fifo_full,
    input  logic        clr_err,
    output logic        fifo_wr_en,
    output logic [47:0] fifo_din,
    output logic [10:0] line_num,
    output logic        frame_start,
    output logic        line_done,
    output logic        len_err,
    output logic        ovf_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DE,
        ACTIVE,
        DROP,
        FRAME_DONE
    } state_t;

    localparam logic [10:0] H_MAX  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [23:0] hold_q, hold_d;
    logic [10:0] line_num_q, line_num_d;
    logic        frame_start_q, frame_start_d;
    logic        line_done_q, line_done_d;
    logic        fifo_wr_en_q, fifo_wr_en_d;
    logic [47:0] fifo_din_q, fifo_din_d;
    logic        len_err_q, len_err_d;
    logic        ovf_err_q, ovf_err_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;

    logic        vs_i, hs_i;
    logic        vs_rise, de_rise, de_fall;
    logic        len_set, ovf_set;
    logic [10:0] cnt_inc;

    // Edges compare the live input against its registered copy so a pixel is consumed on the cycle it arrives.
    assign vs_i    = vsync ^ hvsync_polarity;
    assign hs_i    = hsync ^ hvsync_polarity;
    assign vs_rise = vs_i & ~vs_q;
    assign de_rise = de & ~de_q;
    assign de_fall = ~de & de_q;
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign vs_d    = vs_i;
    assign de_d    = de;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        line_num_d    = line_num_q;
        frame_start_d = 1'b0;
        line_done_d   = 1'b0;
        fifo_wr_en_d  = 1'b0;
        fifo_din_d    = fifo_din_q;
        len_set       = 1'b0;
        ovf_set       = 1'b0;

        if (vs_rise) begin
            state_d       = WAIT_DE;
            line_num_d    = 11'd0;
            cnt_d         = 11'd0;
            frame_start_d = 1'b1;
            if (state_q == ACTIVE || state_q == DROP) begin
                len_set = 1'b1;
            end
        end else begin
            case (state_q)
                WAIT_DE: begin
                    if (de_rise) begin
                        state_d = ACTIVE;
                        cnt_d   = 11'd1;
                        hold_d  = pixel;
                        if (hs_i) begin
                            len_set = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (de_fall) begin
                        state_d = WAIT_DE;
                        if (cnt_q == H_MAX) begin
                            line_done_d = 1'b1;
                            if (line_num_q == V_LAST) begin
                                state_d = FRAME_DONE;
                            end else begin
                                line_num_d = line_num_q + 11'd1;
                            end
                        end else begin
                            len_set = 1'b1;
                        end
                    end else if (de) begin
                        cnt_d = cnt_inc;
                        // An odd count means one pixel is already held, so this one completes a word.
                        if (cnt_q < H_MAX) begin
                            if (cnt_q[0]) begin
                                if (fifo_full) begin
                                    ovf_set = 1'b1;
                                    state_d = DROP;
                                end else begin
                                    fifo_wr_en_d = 1'b1;
                                    fifo_din_d   = {hold_q, pixel};
                                end
                            end else begin
                                hold_d = pixel;
                            end
                        end
                    end
                end
                DROP: begin
                    if (de_fall) begin
                        state_d = WAIT_DE;
                    end
                end
                default: begin
                end
            endcase
        end

        len_err_d = len_set | (len_err_q & ~clr_err);
        ovf_err_d = ovf_set | (ovf_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 11'd0;
            hold_q        <= 24'd0;
            line_num_q    <= 11'd0;
            frame_start_q <= 1'b0;
            line_done_q   <= 1'b0;
            fifo_wr_en_q  <= 1'b0;
            fifo_din_q    <= 48'd0;
            len_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            line_num_q    <= line_num_d;
            frame_start_q <= frame_start_d;
            line_done_q   <= line_done_d;
            fifo_wr_en_q  <= fifo_wr_en_d;
            fifo_din_q    <= fifo_din_d;
            len_err_q     <= len_err_d;
            ovf_err_q     <= ovf_err_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
        end
    end

    assign fifo_wr_en  = fifo_wr_en_q;
    assign fifo_din    = fifo_din_q;
    assign line_num    = line_num_q;
    assign frame_start = frame_start_q;
    assign line_done   = line_done_q;
    assign len_err     = len_err_q;
    assign ovf_err     = ovf_err_q;

endmodule
